// File: rtl/uart_tx_scheduler.sv
// Merges processor stores and debug bytes into one FIFO, then paces them to a UART
// transmitter with a programmable idle gap after every completed frame.
module uart_tx_scheduler #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       memwrite_uart,
   input  logic [7:0] TxData,
   input  logic       dbg_valid,
   input  logic [7:0] dbg_data,
   output logic       dbg_ready,
   output logic       stall_uart,
   output logic       TxStart,
   output logic [7:0] TxData_s,
   input  logic       TxDone,
   output logic [4:0] fifo_count,
   output logic       busy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]    count_q, count_d;
   logic          rr_q;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          tx_start_q;
   logic [7:0]    tx_data_q;
   logic [7:0]    mem_q [DEPTH];

   logic       full, empty;
   logic       proc_ok, dbg_ok;
   logic       push_proc, push_dbg, push, pop, load;
   logic [7:0] push_byte;

   // Occupancy comes from registered state only, so a pop never frees a slot in the same cycle.
   assign full  = (count_q == 5'(DEPTH));
   assign empty = (count_q == 5'd0);

   assign proc_ok = !full && (!dbg_valid || !rr_q);
   assign dbg_ok  = !full && (!memwrite_uart || rr_q);

   assign stall_uart = memwrite_uart && !proc_ok;
   assign dbg_ready  = dbg_valid && dbg_ok;

   assign push_proc = memwrite_uart && proc_ok;
   assign push_dbg  = dbg_valid && dbg_ok && !push_proc;
   assign push      = push_proc || push_dbg;
   assign push_byte = push_proc ? TxData : dbg_data;

   // The head byte is captured on the way into LOAD so it is already valid alongside TxStart.
   assign load = (state_q == S_IDLE) && !empty;
   assign pop  = (state_q == S_LOAD);

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (TxDone) begin
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES) begin
               gap_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_q       <= 1'b0;
         gap_cnt_q  <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         count_q    <= count_d;
         tx_start_q <= load;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (memwrite_uart && dbg_valid && push) rr_q <= !rr_q;
         if (load) tx_data_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_byte;
   end

   assign TxStart    = tx_start_q;
   assign TxData_s   = tx_data_q;
   assign fifo_count = count_q;
   assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: reset, single store, contention, fill/stall, gap spacing, wrap, reset mid-op.
module tb_uart_tx_scheduler;
   localparam int DEPTH = 8;
   localparam int GAP   = 2;

   logic       clk = 1'b0;
   logic       Reset;
   logic       memwrite_uart;
   logic [7:0] TxData;
   logic       dbg_valid;
   logic [7:0] dbg_data;
   logic       dbg_ready;
   logic       stall_uart;
   logic       TxStart;
   logic [7:0] TxData_s;
   logic       TxDone;
   logic [4:0] fifo_count;
   logic       busy;
   logic       TxDone_man;
   logic       TxDone_auto;

   uart_tx_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .memwrite_uart(memwrite_uart),
      .TxData       (TxData),
      .dbg_valid    (dbg_valid),
      .dbg_data     (dbg_data),
      .dbg_ready    (dbg_ready),
      .stall_uart   (stall_uart),
      .TxStart      (TxStart),
      .TxData_s     (TxData_s),
      .TxDone       (TxDone),
      .fifo_count   (fifo_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   assign TxDone = TxDone_man | TxDone_auto;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [7:0] tx_log[$];
   logic [7:0] exp_q[$];
   bit auto_done = 1'b0;
   int done_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (TxStart) begin
         tx_log.push_back(TxData_s);
         $display("tx byte %02h at cycle %0d", TxData_s, cyc);
      end
   end

   // Simple transmitter model: TxDone three cycles after each TxStart when enabled.
   always @(negedge clk) begin
      TxDone_auto = 1'b0;
      if (!auto_done) done_cnt = 0;
      else if (TxStart) done_cnt = 3;
      else if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) TxDone_auto = 1'b1;
      end
   end

   task automatic store(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      memwrite_uart = 1'b1;
      TxData = b;
      #1;
      while (stall_uart && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) check_val("store_timeout", 32'(stall_uart), 32'd0);
   endtask

   task automatic release_store();
      @(negedge clk);
      memwrite_uart = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int max);
      int n = 0;
      #1;
      while (!TxStart && n < max) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val({tag, "_start"}, 32'(TxStart), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (busy && n < max) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_drain"}, 32'(busy), 32'd0);
   endtask

   task automatic check_log(input string tag, input int base);
      check_val({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < tx_log.size())
            check_val($sformatf("%s_b%0d", tag, i), 32'(tx_log[base + i]), 32'(exp_q[i]));
   endtask

   initial begin
      int base;
      int n;
      int c0;
      Reset = 1'b0;
      memwrite_uart = 1'b0;
      TxData = 8'h00;
      dbg_valid = 1'b0;
      dbg_data = 8'h00;
      TxDone_man = 1'b0;

      // Reset state
      #2;
      check_val("rst_txstart", 32'(TxStart), 32'd0);
      check_val("rst_txdata", 32'(TxData_s), 32'h00);
      check_val("rst_count", 32'(fifo_count), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      memwrite_uart = 1'b1;
      dbg_valid = 1'b1;
      #1;
      check_val("rst_stall", 32'(stall_uart), 32'd0);
      check_val("rst_dbg_ready", 32'(dbg_ready), 32'd0);
      memwrite_uart = 1'b0;
      dbg_valid = 1'b0;
      repeat (2) @(negedge clk);
      Reset = 1'b1;

      // Single store
      base = tx_log.size();
      @(negedge clk); memwrite_uart = 1'b1; TxData = 8'h41; #1;
      check_val("single_stall", 32'(stall_uart), 32'd0);
      check_val("single_cnt0", 32'(fifo_count), 32'd0);
      @(negedge clk); memwrite_uart = 1'b0; #1;
      check_val("single_cnt1", 32'(fifo_count), 32'd1);
      check_val("single_nostart", 32'(TxStart), 32'd0);
      @(negedge clk); #1;
      check_val("single_start", 32'(TxStart), 32'd1);
      check_val("single_data", 32'(TxData_s), 32'h41);
      TxDone_man = 1'b1;
      @(negedge clk); TxDone_man = 1'b0; #1;
      check_val("single_pulse", 32'(TxStart), 32'd0);
      check_val("single_cnt_end", 32'(fifo_count), 32'd0);
      repeat (3) @(negedge clk);
      check_val("single_done_in_load_ignored", 32'(busy), 32'd1);
      check_val("single_data_stable", 32'(TxData_s), 32'h41);
      @(negedge clk); TxDone_man = 1'b1;
      @(negedge clk); TxDone_man = 1'b0; #1;
      check_val("single_gap1_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
      check_val("single_gap2_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
      check_val("single_idle", 32'(busy), 32'd0);

      // Contention and round-robin
      auto_done = 1'b1;
      base = tx_log.size();
      @(negedge clk);
      memwrite_uart = 1'b1; TxData = 8'hAA; dbg_valid = 1'b1; dbg_data = 8'h55; #1;
      check_val("cont1_stall", 32'(stall_uart), 32'd0);
      check_val("cont1_dbg_ready", 32'(dbg_ready), 32'd0);
      @(negedge clk); #1;
      check_val("cont2_stall", 32'(stall_uart), 32'd1);
      check_val("cont2_dbg_ready", 32'(dbg_ready), 32'd1);
      check_val("cont2_count", 32'(fifo_count), 32'd1);
      @(negedge clk); TxData = 8'hBB; dbg_data = 8'h66; #1;
      check_val("cont3_stall", 32'(stall_uart), 32'd0);
      check_val("cont3_dbg_ready", 32'(dbg_ready), 32'd0);
      check_val("cont3_start", 32'(TxStart), 32'd1);
      check_val("cont3_data", 32'(TxData_s), 32'hAA);
      check_val("cont3_count", 32'(fifo_count), 32'd2);
      @(negedge clk); memwrite_uart = 1'b0; dbg_valid = 1'b0; #1;
      check_val("cont4_count", 32'(fifo_count), 32'd2);
      wait_idle("cont", 300);
      exp_q = '{8'hAA, 8'h55, 8'hBB};
      check_log("cont_order", base);

      // Fill with the transmitter held busy
      auto_done = 1'b0;
      base = tx_log.size();
      store(8'hF0);
      release_store();
      wait_start("fill_first", 10);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); memwrite_uart = 1'b1; TxData = 8'(i); #1;
         if (i < 8) check_val($sformatf("fill_nostall%0d", i), 32'(stall_uart), 32'd0);
         else begin
            check_val("fill_full_stall", 32'(stall_uart), 32'd1);
            check_val("fill_full_count", 32'(fifo_count), 32'd8);
         end
      end
      @(negedge clk); TxDone_man = 1'b1; #1;
      check_val("fill_stall_at_done", 32'(stall_uart), 32'd1);
      n = 0;
      do begin
         @(negedge clk); TxDone_man = 1'b0; #1;
         n++;
      end while (stall_uart && n < 20);
      check_val("fill_release_cycles", 32'(n), 32'd5);
      @(negedge clk); memwrite_uart = 1'b0; #1;
      check_val("fill_refull_count", 32'(fifo_count), 32'd8);
      @(negedge clk); TxDone_man = 1'b1;
      @(negedge clk); TxDone_man = 1'b0; auto_done = 1'b1;
      wait_idle("fill", 600);
      exp_q = '{8'hF0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      check_log("fill_order", base);

      // Gap spacing: TxDone in cycle N gives TxStart in cycle N+4
      auto_done = 1'b0;
      store(8'h11);
      store(8'h22);
      release_store();
      wait_start("gap_first", 10);
      repeat (2) @(negedge clk);
      @(negedge clk); TxDone_man = 1'b1; c0 = cyc;
      @(negedge clk); TxDone_man = 1'b0;
      wait_start("gap_second", 20);
      check_val("gap_spacing", 32'(cyc - c0), 32'd4);
      check_val("gap_data", 32'(TxData_s), 32'h22);
      @(negedge clk);
      @(negedge clk); TxDone_man = 1'b1;
      @(negedge clk); TxDone_man = 1'b0;
      wait_idle("gap", 50);

      // Pointer wrap: 20 bytes through the 8-entry FIFO
      auto_done = 1'b1;
      base = tx_log.size();
      exp_q = {};
      for (int i = 0; i < 20; i++) begin
         store(8'(i * 13 + 5));
         exp_q.push_back(8'(i * 13 + 5));
      end
      release_store();
      wait_idle("wrap", 1000);
      check_log("wrap_order", base);
      check_val("wrap_count", 32'(fifo_count), 32'd0);

      // Reset in the middle of a transmission
      auto_done = 1'b0;
      store(8'hA1); store(8'hA2); store(8'hA3); store(8'hA4);
      release_store();
      repeat (2) @(negedge clk);
      #1;
      check_val("rstmid_count_before", 32'(fifo_count), 32'd3);
      check_val("rstmid_busy_before", 32'(busy), 32'd1);
      @(negedge clk); Reset = 1'b0; #1;
      check_val("rstmid_count", 32'(fifo_count), 32'd0);
      check_val("rstmid_txstart", 32'(TxStart), 32'd0);
      check_val("rstmid_txdata", 32'(TxData_s), 32'h00);
      check_val("rstmid_busy", 32'(busy), 32'd0);
      @(negedge clk); Reset = 1'b1;
      base = tx_log.size();
      repeat (10) @(negedge clk);
      #1;
      check_val("rstmid_no_start", 32'(tx_log.size() - base), 32'd0);
      store(8'h5A);
      release_store();
      wait_start("rstmid_after", 10);
      check_val("rstmid_after_data", 32'(TxData_s), 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
